instr_fetch_ctrl: RTL and testbench

//  Fetch sequencer for the combinational 16-bit instruction ROM.
//  - Owns the PC and drives the ROM address.
//  - Captures each returned word with its PC into a 2-entry prefetch queue.
//  - Hands instructions to decode over a valid/ready handshake.
//  - Handles branch redirects (with queue flush) and HALT/resume.

---
 rtl/instr_fetch_ctrl_pkg.sv | 39 +++
 rtl/instr_fetch_ctrl_fetch_queue.sv | 46 ++++
 rtl/instr_fetch_ctrl.sv | 105 ++++++++++
 tb/tb_instr_fetch_ctrl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/instr_fetch_ctrl_pkg.sv
// Shared types and constants for the instruction fetch sequencer.
// Widths, ROM depth, HALT opcode and PC helpers.
package instr_fetch_ctrl_pkg;

  localparam int ADDR_W     = 16;
  localparam int INSTR_W    = 16;
  localparam int IMEM_DEPTH = 64;
  localparam int OP_MSB     = 15;
  localparam int OP_LSB     = 12;

  localparam logic [ADDR_W-1:0] RESET_PC = 16'h0;
  localparam logic [3:0]        HALT_OP  = 4'hF;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;

  // Sequential PC step; wraps at the end of the populated ROM.
  function automatic logic [ADDR_W-1:0] pc_inc(
    input logic [ADDR_W-1:0] pc
  );
    if (pc == ADDR_W'(IMEM_DEPTH - 1))
      return '0;
    return pc + 1'b1;
  endfunction

  function automatic logic is_halt(
    input logic [INSTR_W-1:0] word
  );
    return word[OP_MSB:OP_LSB] == HALT_OP;
  endfunction

endpackage

// File: rtl/instr_fetch_ctrl_fetch_queue.sv
// Two-entry prefetch FIFO of {pc, instr}.
// Head is always entry 0; flush beats push.
module fetch_queue
  import instr_fetch_ctrl_pkg::*;
(
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic         pop,
  input  logic         flush,
  input  fetch_entry_t wdata,
  output logic [1:0]   count,
  output fetch_entry_t head
);

  fetch_entry_t e0;
  fetch_entry_t e1;
  logic         push_ok;
  logic         pop_ok;

  assign pop_ok  = pop && (count != 2'd0);
  assign push_ok = push && ((count != 2'd2) || pop_ok);
  assign head    = e0;

  // Shift-style storage: pop moves entry 1 down, push fills next free slot.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= 2'd0;
      e0    <= '0;
      e1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (pop_ok && count == 2'd2)
        e0 <= e1;
      if (push_ok) begin
        if (count == 2'd0 || (count == 2'd1 && pop_ok))
          e0 <= wdata;
        else
          e1 <= wdata;
      end
      count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
    end
  end

endmodule

// File: rtl/instr_fetch_ctrl.sv
// Fetch sequencer: owns PC, fills the prefetch queue from the ROM,
// hands words to decode, handles redirects and HALT/resume.
module instr_fetch_ctrl
  import instr_fetch_ctrl_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_data,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  output logic               instr_valid,
  input  logic               instr_ready,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  output logic               halted,
  input  logic               resume,
  output logic [15:0]        fetch_count
);

  fetch_state_e      state;
  logic [ADDR_W-1:0] pc;
  logic [1:0]        count;
  logic [1:0]        count_d;
  fetch_entry_t      head;
  fetch_entry_t      wdata;
  logic              push;
  logic              pop;
  logic              halt_d;

  assign imem_addr   = pc;
  assign instr_valid = count != 2'd0;
  assign instr       = head.instr;
  assign instr_pc    = head.pc;
  assign pop         = instr_valid && instr_ready;
  assign wdata       = '{pc: pc, instr: imem_data};

  // Push while running with room, or when full and the head leaves.
  always_comb begin
    push = 1'b0;
    if (state == RUN && !redirect_valid)
      push = (count != 2'd2) || pop;
  end

  // Next queue occupancy and next HALT state, used for the halted flag.
  always_comb begin
    count_d = count;
    halt_d  = 1'b0;
    unique case (1'b1)
      redirect_valid: begin
        count_d = 2'd0;
        halt_d  = 1'b0;
      end
      default: begin
        count_d = count + {1'b0, push} - {1'b0, pop};
        halt_d  = (state == HALT && !resume) ||
                  (push && is_halt(imem_data));
      end
    endcase
  end

  // PC, run/halt FSM, halted flag and saturating push counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      state       <= RUN;
      halted      <= 1'b0;
      fetch_count <= 16'h0;
    end else begin
      halted <= halt_d && (count_d == 2'd0);
      if (push && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'h1;
      if (redirect_valid) begin
        pc    <= redirect_target;
        state <= RUN;
      end else begin
        if (push)
          pc <= pc_inc(pc);
        case (state)
          RUN: begin
            if (push && is_halt(imem_data))
              state <= HALT;
          end
          HALT: begin
            if (resume)
              state <= RUN;
          end
          default: state <= RUN;
        endcase
      end
    end
  end

  fetch_queue u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (wdata),
    .count (count),
    .head  (head)
  );

endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// Directed self-checking bench for instr_fetch_ctrl.
// ROM is a bench-side array read combinationally.
module tb_instr_fetch_ctrl;
  import instr_fetch_ctrl_pkg::*;

  logic               clk = 1'b0;
  logic               rst = 1'b1;
  logic [ADDR_W-1:0]  imem_addr;
  logic [INSTR_W-1:0] imem_data;
  logic               redirect_valid = 1'b0;
  logic [ADDR_W-1:0]  redirect_target = '0;
  logic               instr_valid;
  logic               instr_ready = 1'b0;
  logic [INSTR_W-1:0] instr;
  logic [ADDR_W-1:0]  instr_pc;
  logic               halted;
  logic               resume = 1'b0;
  logic [15:0]        fetch_count;

  logic [15:0] rom [64];
  int total  = 0;
  int passed = 0;

  always #5 clk = ~clk;

  assign imem_data = (imem_addr < 16'd64) ? rom[imem_addr[5:0]] : 16'h0;

  instr_fetch_ctrl dut (
    .clk             (clk),
    .rst             (rst),
    .imem_addr       (imem_addr),
    .imem_data       (imem_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .halted          (halted),
    .resume          (resume),
    .fetch_count     (fetch_count)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic init_rom;
    for (int i = 0; i < 64; i++)
      rom[i] = (i < 6) ? 16'(i + 1) : 16'h0100 + 16'(i);
  endtask

  task automatic do_reset;
    rst = 1'b1;
    redirect_valid = 1'b0;
    resume = 1'b0;
    instr_ready = 1'b0;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset;
    init_rom();
    do_reset();
    total++;
    if (instr_valid !== 1'b0)
      $display("FAIL reset_valid: got %0b want 0", instr_valid);
    else passed++;
    total++;
    if (instr !== 16'h0)
      $display("FAIL reset_instr: got %0h want 0", instr);
    else passed++;
    total++;
    if (instr_pc !== 16'h0)
      $display("FAIL reset_pc: got %0h want 0", instr_pc);
    else passed++;
    total++;
    if (halted !== 1'b0)
      $display("FAIL reset_halted: got %0b want 0", halted);
    else passed++;
    total++;
    if (fetch_count !== 16'h0)
      $display("FAIL reset_count: got %0h want 0", fetch_count);
    else passed++;
    total++;
    if (imem_addr !== 16'h0)
      $display("FAIL reset_addr: got %0h want 0", imem_addr);
    else passed++;
  endtask

  task automatic test_stream;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instr !== 16'(i + 1) ||
          instr_pc !== 16'(i))
        $display("FAIL stream_%0d: got v=%0b i=%0h pc=%0h want v=1 i=%0h pc=%0h",
                 i, instr_valid, instr, instr_pc, i + 1, i);
      else passed++;
    end
    total++;
    if (fetch_count !== 16'd6)
      $display("FAIL stream_count: got %0d want 6", fetch_count);
    else passed++;
  endtask

  task automatic test_backpressure;
    do_reset();
    for (int c = 0; c < 5; c++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instr !== 16'h1 || instr_pc !== 16'h0)
        $display("FAIL stall_hold_%0d: got v=%0b i=%0h pc=%0h want v=1 i=1 pc=0",
                 c, instr_valid, instr, instr_pc);
      else passed++;
    end
    total++;
    if (imem_addr !== 16'd2 || fetch_count !== 16'd2)
      $display("FAIL stall_pc: got addr=%0h cnt=%0d want addr=2 cnt=2",
               imem_addr, fetch_count);
    else passed++;
    instr_ready = 1'b1;
    for (int j = 0; j < 6; j++) begin
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(j) ||
          instr !== 16'(j + 1))
        $display("FAIL stall_release_%0d: got v=%0b pc=%0h i=%0h want pc=%0h i=%0h",
                 j, instr_valid, instr_pc, instr, j, j + 1);
      else passed++;
      tick();
    end
  endtask

  task automatic test_redirect;
    do_reset();
    tick();
    tick();
    instr_ready = 1'b1;
    tick();
    tick();
    instr_ready = 1'b0;
    total++;
    if (instr_pc !== 16'd2 || imem_addr !== 16'd4)
      $display("FAIL redir_setup: got pc=%0h addr=%0h want pc=2 addr=4",
               instr_pc, imem_addr);
    else passed++;
    redirect_valid = 1'b1;
    redirect_target = 16'd20;
    tick();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
    total++;
    if (instr_valid !== 1'b0 || imem_addr !== 16'd20)
      $display("FAIL redir_bubble: got v=%0b addr=%0h want v=0 addr=14",
               instr_valid, imem_addr);
    else passed++;
    tick();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'd20 ||
        instr !== 16'h0114)
      $display("FAIL redir_target: got v=%0b pc=%0h i=%0h want v=1 pc=14 i=114",
               instr_valid, instr_pc, instr);
    else passed++;
    total++;
    if (fetch_count !== 16'd5)
      $display("FAIL redir_count: got %0d want 5", fetch_count);
    else passed++;
    tick();
    total++;
    if (instr_pc !== 16'd21)
      $display("FAIL redir_next: got %0h want 15", instr_pc);
    else passed++;
  endtask

  task automatic test_halt;
    rom[3] = 16'hF000;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== 16'(i) || halted !== 1'b0)
        $display("FAIL halt_seq_%0d: got v=%0b pc=%0h h=%0b want v=1 pc=%0h h=0",
                 i, instr_valid, instr_pc, halted, i);
      else passed++;
    end
    total++;
    if (instr !== 16'hF000)
      $display("FAIL halt_word: got %0h want f000", instr);
    else passed++;
    tick();
    total++;
    if (halted !== 1'b1 || instr_valid !== 1'b0 || imem_addr !== 16'd4)
      $display("FAIL halt_enter: got h=%0b v=%0b addr=%0h want h=1 v=0 addr=4",
               halted, instr_valid, imem_addr);
    else passed++;
    tick();
    total++;
    if (halted !== 1'b1 || fetch_count !== 16'd4 || imem_addr !== 16'd4)
      $display("FAIL halt_hold: got h=%0b cnt=%0d addr=%0h want h=1 cnt=4 addr=4",
               halted, fetch_count, imem_addr);
    else passed++;
    resume = 1'b1;
    tick();
    resume = 1'b0;
    total++;
    if (halted !== 1'b0)
      $display("FAIL halt_resume: got h=%0b want 0", halted);
    else passed++;
    tick();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'd4 || instr !== 16'd5)
      $display("FAIL halt_restart: got v=%0b pc=%0h i=%0h want v=1 pc=4 i=5",
               instr_valid, instr_pc, instr);
    else passed++;
    rom[3] = 16'd4;
  endtask

  task automatic test_wrap;
    logic [15:0] exp_pc [4];
    exp_pc[0] = 16'd62;
    exp_pc[1] = 16'd63;
    exp_pc[2] = 16'd0;
    exp_pc[3] = 16'd1;
    do_reset();
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_target = 16'd62;
    tick();
    redirect_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (instr_valid !== 1'b1 || instr_pc !== exp_pc[i] ||
          instr !== rom[exp_pc[i][5:0]])
        $display("FAIL wrap_%0d: got v=%0b pc=%0h i=%0h want pc=%0h i=%0h",
                 i, instr_valid, instr_pc, instr, exp_pc[i],
                 rom[exp_pc[i][5:0]]);
      else passed++;
    end
  endtask

  task automatic test_mid_reset;
    do_reset();
    tick();
    tick();
    tick();
    total++;
    if (instr_valid !== 1'b1 || imem_addr !== 16'd2)
      $display("FAIL mrst_full: got v=%0b addr=%0h want v=1 addr=2",
               instr_valid, imem_addr);
    else passed++;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    total++;
    if (instr_valid !== 1'b0 || fetch_count !== 16'h0 ||
        imem_addr !== RESET_PC)
      $display("FAIL mrst_clear: got v=%0b cnt=%0d addr=%0h want v=0 cnt=0 addr=0",
               instr_valid, fetch_count, imem_addr);
    else passed++;
    instr_ready = 1'b1;
    tick();
    total++;
    if (instr_valid !== 1'b1 || instr_pc !== 16'h0 || instr !== 16'h1)
      $display("FAIL mrst_restart: got v=%0b pc=%0h i=%0h want v=1 pc=0 i=1",
               instr_valid, instr_pc, instr);
    else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_halt();
    test_wrap();
    test_mid_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
